// File: rtl/led_pkg.sv
// Shared constants, types and helpers for the LED pattern generator.
// Holds the mode encodings, the scan direction type and the start value function.
package led_pkg;

    localparam logic [1:0] MODE_BLINK = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;
    localparam logic [1:0] MODE_FILL  = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Value the LED bank shows right after entering a mode.
    // Only SCAN starts non-zero (a single lit bit0).
    function automatic int unsigned start_val(
        input logic [1:0] mode,
        input int         width
    );
        if (mode == MODE_SCAN && width >= 2)
            return 1;
        return 0;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Generic prescaler: counts 0..DIV-1 while en=1 and pulses tick on the last count.
// Ports: clk, rst_n (async active-low), en (count enable), clr (sync clear), tick (out).
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // clr wins over counting so a caller can realign the step phase at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern driver: prescaled step clock advancing BLINK/COUNT/SCAN/FILL patterns.
// Ports: clk, rst_n (async active-low), enable, mode[1:0], LED[WIDTH-1:0], step (pulse).
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] LED,
    output logic             step
);

    localparam int DIV = CLK_HZ / STEP_HZ;

    logic [1:0]       mode_q;
    logic             mode_chg;
    logic             tick;
    logic [WIDTH-1:0] led_start;
    logic [WIDTH-1:0] led_next;
    dir_t             dir;
    dir_t             dir_next;

    assign mode_chg  = (mode != mode_q);
    assign led_start = WIDTH'(start_val(mode, WIDTH));

    tick_divider #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .clr   (mode_chg),
        .tick  (tick)
    );

    // A mode change restarts the new pattern and outranks a coincident tick.
    always_comb begin
        led_next = LED;
        dir_next = dir;
        if (mode_chg) begin
            led_next = led_start;
            dir_next = DIR_UP;
        end else if (tick) begin
            unique case (mode_q)
                MODE_BLINK: led_next = ~LED;
                MODE_COUNT: led_next = LED + 1'b1;
                MODE_SCAN: begin
                    if (!$onehot(LED)) begin
                        led_next = {{(WIDTH-1){1'b0}}, 1'b1};
                        dir_next = DIR_UP;
                    end else if (dir == DIR_UP) begin
                        led_next = LED << 1;
                        if (led_next[WIDTH-1])
                            dir_next = DIR_DOWN;
                    end else begin
                        led_next = LED >> 1;
                        if (led_next[0])
                            dir_next = DIR_UP;
                    end
                end
                MODE_FILL: begin
                    if (&LED)
                        led_next = '0;
                    else
                        led_next = {LED[WIDTH-2:0], 1'b1};
                end
                default: led_next = LED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BLINK;
            LED    <= '0;
            dir    <= DIR_UP;
            step   <= 1'b0;
        end else begin
            mode_q <= mode;
            LED    <= led_next;
            dir    <= dir_next;
            step   <= tick && !mode_chg;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (WIDTH=8, DIV=4).
// Reference model tracks step index per mode and derives LED values arithmetically.
module tb_led_pattern_gen;

    localparam int W   = 8;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] LED;
    logic         step;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] m_mode_q;
    int         m_k;
    int         m_phase;
    logic       m_step;

    led_pattern_gen #(
        .WIDTH   (W),
        .CLK_HZ  (8),
        .STEP_HZ (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .mode   (mode),
        .LED    (LED),
        .step   (step)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input logic [1:0] md, input int k);
        int p;
        case (md)
            2'b00: return (k % 2 == 1) ? {W{1'b1}} : '0;
            2'b01: return W'(k % (1 << W));
            2'b10: begin
                p = k % (2 * (W - 1));
                if (p > W - 1)
                    p = 2 * (W - 1) - p;
                return W'(1 << p);
            end
            default: begin
                p = k % (W + 1);
                return W'((1 << p) - 1);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_mode_q = 2'b00;
        m_k      = 0;
        m_phase  = 0;
        m_step   = 1'b0;
    endtask

    task automatic advance(input logic e, input logic [1:0] md);
        enable = e;
        mode   = md;
        @(posedge clk);
        if (md != m_mode_q) begin
            m_mode_q = md;
            m_k      = 0;
            m_phase  = 0;
            m_step   = 1'b0;
        end else if (e) begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_k++;
                m_step = 1'b1;
            end else begin
                m_step = 1'b0;
            end
        end else begin
            m_step = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        mode   = 2'b00;
        model_reset();
        #12;
        n_checks++;
        if (LED !== '0 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: LED=%h step=%b, want LED=00 step=0", LED, step);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            advance(1'b1, 2'b00);
            n_checks++;
            if (LED !== pat(m_mode_q, m_k) || step !== m_step) begin
                n_fail++;
                $display("FAIL blink cyc%0d: LED=%h step=%b, want %h %b",
                         i, LED, step, pat(m_mode_q, m_k), m_step);
            end
            if (i == 4) begin
                n_checks++;
                if (LED !== 8'hFF || step !== 1'b1) begin
                    n_fail++;
                    $display("FAIL blink_first_step: LED=%h step=%b, want FF 1", LED, step);
                end
            end
        end
    endtask

    task automatic test_count();
        int dut_steps = 0;
        int m_steps = 0;
        int guard = 0;
        logic e;
        advance(1'b1, 2'b01);
        while (m_k < 260 && guard < 3000) begin
            e = ($urandom_range(0, 7) != 0);
            advance(e, 2'b01);
            guard++;
            if (step === 1'b1) dut_steps++;
            if (m_step) m_steps++;
            n_checks++;
            if (LED !== pat(m_mode_q, m_k) || step !== m_step) begin
                n_fail++;
                $display("FAIL count k%0d: LED=%h step=%b, want %h %b",
                         m_k, LED, step, pat(m_mode_q, m_k), m_step);
            end
        end
        n_checks++;
        if (guard >= 3000 || dut_steps != 260 || m_steps != 260 || LED !== 8'h04) begin
            n_fail++;
            $display("FAIL count_total: steps=%0d LED=%h, want 260 04", dut_steps, LED);
        end
    endtask

    task automatic test_scan();
        logic [W-1:0] exp_tab [16];
        int idx = 0;
        exp_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        advance(1'b1, 2'b10);
        n_checks++;
        if (LED !== 8'h01 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_start: LED=%h step=%b, want 01 0", LED, step);
        end
        for (int c = 0; c < 16 * DIV; c++) begin
            advance(1'b1, 2'b10);
            n_checks++;
            if (LED !== pat(m_mode_q, m_k) || step !== m_step) begin
                n_fail++;
                $display("FAIL scan cyc%0d: LED=%h step=%b, want %h %b",
                         c, LED, step, pat(m_mode_q, m_k), m_step);
            end
            if (step === 1'b1 && idx < 16) begin
                n_checks++;
                if (LED !== exp_tab[idx]) begin
                    n_fail++;
                    $display("FAIL scan_tab%0d: LED=%h, want %h", idx, LED, exp_tab[idx]);
                end
                idx++;
            end
        end
        n_checks++;
        if (idx != 16) begin
            n_fail++;
            $display("FAIL scan_steps: got %0d, want 16", idx);
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] exp_tab [9];
        int idx = 0;
        exp_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        advance(1'b1, 2'b11);
        for (int c = 0; c < 9 * DIV; c++) begin
            advance(1'b1, 2'b11);
            n_checks++;
            if (LED !== pat(m_mode_q, m_k) || step !== m_step) begin
                n_fail++;
                $display("FAIL fill cyc%0d: LED=%h step=%b, want %h %b",
                         c, LED, step, pat(m_mode_q, m_k), m_step);
            end
            if (step === 1'b1 && idx < 9) begin
                n_checks++;
                if (LED !== exp_tab[idx]) begin
                    n_fail++;
                    $display("FAIL fill_tab%0d: LED=%h, want %h", idx, LED, exp_tab[idx]);
                end
                idx++;
            end
        end
    endtask

    task automatic test_enable_mode_change();
        int gap = -1;
        advance(1'b1, 2'b01);
        for (int c = 0; c < 42 * DIV; c++)
            advance(1'b1, 2'b01);
        n_checks++;
        if (LED !== 8'h2A) begin
            n_fail++;
            $display("FAIL count_2a: LED=%h, want 2A", LED);
        end
        for (int c = 0; c < 10; c++) begin
            advance(1'b0, 2'b01);
            n_checks++;
            if (LED !== 8'h2A || step !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cyc%0d: LED=%h step=%b, want 2A 0", c, LED, step);
            end
        end
        advance(1'b1, 2'b10);
        n_checks++;
        if (LED !== 8'h01 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_switch: LED=%h step=%b, want 01 0", LED, step);
        end
        for (int c = 1; c <= 8; c++) begin
            advance(1'b1, 2'b10);
            if (step === 1'b1 && gap < 0) gap = c;
        end
        n_checks++;
        if (gap != DIV) begin
            n_fail++;
            $display("FAIL step_after_clear: gap=%0d, want %0d", gap, DIV);
        end
    endtask

    task automatic test_async_reset();
        int n = $urandom_range(5, 30);
        for (int c = 0; c < n; c++)
            advance(1'b1, 2'b10);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (LED !== '0 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: LED=%h step=%b, want 00 0", LED, step);
        end
        @(negedge clk);
        rst_n = 1'b1;
        advance(1'b1, 2'b10);
        n_checks++;
        if (LED !== 8'h01 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_scan: LED=%h step=%b, want 01 0", LED, step);
        end
        for (int c = 0; c < 20; c++) begin
            advance(1'b1, 2'b10);
            n_checks++;
            if (LED !== pat(m_mode_q, m_k) || step !== m_step) begin
                n_fail++;
                $display("FAIL post_reset cyc%0d: LED=%h step=%b, want %h %b",
                         c, LED, step, pat(m_mode_q, m_k), m_step);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] md = m_mode_q;
        logic e;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0)
                md = 2'($urandom_range(0, 3));
            e = ($urandom_range(0, 3) != 0);
            advance(e, md);
            n_checks++;
            if (LED !== pat(m_mode_q, m_k) || step !== m_step) begin
                n_fail++;
                $display("FAIL random cyc%0d md=%0d: LED=%h step=%b, want %h %b",
                         c, md, LED, step, pat(m_mode_q, m_k), m_step);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_scan();
        test_fill();
        test_enable_mode_change();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
